// File: rtl/mpu6050_target.sv
// I2C target emulating the MPU6050 register subset used by our master (accel, PWR_MGMT_1, WHO_AM_I).
// Optional input glitch filter: define MPU6050_TARGET_GLITCH_FILTER_EN.
module mpu6050_target #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
    parameter logic [7:0] PWR_RST_VAL  = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SCL,
    inout  wire         SDA,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    output logic [7:0]  pwr_mgmt,
    output logic        busy,
    output logic        wr_strobe
);

    // state     | meaning
    // IDLE      | bus free, waiting for START
    // ADDR      | shifting in address + R/W
    // ADDR_ACK  | acknowledging matched address
    // REG       | shifting in register pointer
    // REG_ACK   | acknowledging register pointer
    // WDATA     | shifting in a write data byte
    // WDATA_ACK | acknowledging write data
    // RDATA     | driving a read byte MSB first
    // RACK      | sampling master ACK/NACK
    // WAIT_STOP | ignoring bus until STOP or START
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
    } state_t;

    logic [1:0] scl_sync, sda_sync;
    logic       scl_c, sda_c;
    logic       scl_q, sda_q;
    logic       scl_rise, scl_fall, start_p, stop_p, sda_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
        end
    end

`ifdef MPU6050_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_filt, sda_filt;

    // Majority of the current and two previous samples drops single-clk pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= (scl_sync[1] & scl_hist[0]) | (scl_sync[1] & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
            sda_filt <= (sda_sync[1] & sda_hist[0]) | (sda_sync[1] & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
        end
    end

    assign scl_c = scl_filt;
    assign sda_c = sda_filt;
`else
    assign scl_c = scl_sync[1];
    assign sda_c = sda_sync[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start_p  <= 1'b0;
            stop_p   <= 1'b0;
            sda_bit  <= 1'b1;
        end else begin
            scl_q    <= scl_c;
            sda_q    <= sda_c;
            scl_rise <= scl_c & ~scl_q;
            scl_fall <= ~scl_c & scl_q;
            start_p  <= scl_c & scl_q & sda_q & ~sda_c;
            stop_p   <= scl_c & scl_q & ~sda_q & sda_c;
            sda_bit  <= sda_c;
        end
    end

    function automatic logic [7:0] rd_map(input logic [7:0] a, input logic [47:0] acc,
                                          input logic [7:0] pwr);
        logic [7:0] r;
        case (a)
            8'h3B:   r = acc[47:40];
            8'h3C:   r = acc[39:32];
            8'h3D:   r = acc[31:24];
            8'h3E:   r = acc[23:16];
            8'h3F:   r = acc[15:8];
            8'h40:   r = acc[7:0];
            8'h6B:   r = pwr;
            8'h75:   r = WHO_AM_I_VAL;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [6:0]  shreg;
    logic        rw;
    logic [7:0]  ptr;
    logic [47:0] shadow;
    logic        sda_oe;
    logic [7:0]  shift_next;
    logic [47:0] accel_live;
    logic [7:0]  rd_byte, live_byte;

    assign shift_next = {shreg, sda_bit};
    assign accel_live = {accel_x, accel_y, accel_z};
    assign rd_byte    = rd_map(ptr, shadow, pwr_mgmt);
    // First read byte is driven in the same cycle the shadow is loaded.
    assign live_byte  = rd_map(ptr, accel_live, pwr_mgmt);
    assign SDA        = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 7'd0;
            rw        <= 1'b0;
            ptr       <= 8'h00;
            shadow    <= 48'd0;
            sda_oe    <= 1'b0;
            pwr_mgmt  <= PWR_RST_VAL;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (start_p) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_p) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg <= shift_next[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            if (shift_next[7:1] == DEV_ADDR) begin
                                state <= ADDR_ACK;
                                rw    <= shift_next[0];
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                            busy   <= 1'b1;
                        end else if (rw) begin
                            state   <= RDATA;
                            shadow  <= accel_live;
                            sda_oe  <= ~live_byte[7];
                            bit_cnt <= 4'd0;
                        end else begin
                            state   <= REG;
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                        end
                    end
                    REG: if (scl_rise) begin
                        shreg <= shift_next[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= 4'd0;
                            ptr     <= shift_next;
                            state   <= REG_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    REG_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            state   <= WDATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shreg <= shift_next[6:0];
                        if (bit_cnt == 4'd7) begin
                            bit_cnt   <= 4'd0;
                            if (ptr == 8'h6B) pwr_mgmt <= shift_next;
                            wr_strobe <= 1'b1;
                            ptr       <= ptr + 8'd1;
                            state     <= WDATA_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state   <= RACK;
                                bit_cnt <= 4'd0;
                            end else begin
                                sda_oe <= ~rd_byte[~bit_cnt[2:0]];
                            end
                        end
                    end
                    // bit_cnt==1 marks an ACK seen; next byte starts on the following fall.
                    RACK: begin
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                            if (!sda_bit) begin
                                bit_cnt <= 4'd1;
                            end else begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd1) begin
                            state   <= RDATA;
                            bit_cnt <= 4'd0;
                            sda_oe  <= ~rd_byte[7];
                        end
                    end
                    WAIT_STOP: sda_oe <= 1'b0;
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
